random_server: RTL
==================

Name: random_server

Overview:
- Shares the single free-running 16-bit LFSR word among NREQ requesters, such as the star-field, sprite-jitter and palette-cycling units.
- Round-robin arbitration; each grant returns one bounded random value in [0, limit].
- Enforces FRESH LFSR shifts between consumed words, so consecutive results share no bits.
- Range reduction uses mask-and-reject with a bounded retry fallback.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, LFSR and result width.
- FRESH, 16, minimum clocks between consecutive LFSR samples.
- MAX_RETRY, 8, rejected attempts before the fallback result is used.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- rnd_in  in  WIDTH  LFSR output; advances every clk.
- req  in  NREQ  per-requester request level.
- limit  in  NREQ*WIDTH  inclusive upper bound; requester i uses slice [i*WIDTH +: WIDTH].
- valid  out  NREQ  one-cycle result strobe, one-hot.
- rnd_out  out  WIDTH  result; registered and held until the next strobe.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, valid=0, rnd_out=0, busy=0, fresh_cnt=0, retry=0, rr_ptr=NREQ-1 (req[0] wins first).
- fresh_cnt: increments each clk, saturating at FRESH; cleared in the cycle a sample is captured.
  - After reset, the first capture is possible FRESH clocks later.
- Mask: smallest 2^k-1 >= latched limit. limit=0 gives mask 0; limit=0xFFFF gives mask 0xFFFF.
- IDLE:
  - If req is nonzero, grant the first set bit searching from rr_ptr+1 upward, wrapping at NREQ.
  - Latch the grant index, limit and mask; set retry=0; go to WAIT.
- WAIT: when fresh_cnt==FRESH, capture sample=rnd_in&mask, clear fresh_cnt, go to CHECK.
- CHECK:
  - If sample<=limit, result=sample.
  - Else if retry==MAX_RETRY-1, result=sample-(limit+1). This is always <=limit because mask<=2*limit+1.
  - Else retry++ and return to WAIT.
  - On a result, load rnd_out and go to DONE.
- DONE: valid[grant]=1 for exactly this cycle; rr_ptr<=grant; go to IDLE.
  - The next arbitration happens in the following IDLE cycle, so there is at least one idle cycle between grants.
- Latency with fresh_cnt saturated: req sampled in IDLE at cycle 0 -> WAIT at cycle 1 -> CHECK at 2 -> valid at 3.
  - Each rejection adds FRESH+1 clocks.
- Handshake:
  - Requester holds req until it sees its valid bit, and drops req the next cycle.
  - limit is sampled only at grant; later changes are ignored.
  - A requester that drops req mid-transaction still receives its valid pulse; discarding it is the requester's job.
- Simultaneous requests: exactly one grant per transaction. With all bits held high, grants rotate strictly 0,1,2,3,0,...
- Reset mid-transaction: immediate return to reset values; no valid pulse is produced.

Optional Feature:
- Macro RANDOM_SERVER_STATS_EN.
- Defined:
  - Adds output reject_cnt[15:0], reset 0.
  - Increments on every rejection in CHECK, including the one that triggers the fallback; saturates at 0xFFFF.
  - Adds output fallback_cnt[7:0], which increments on each fallback result and saturates at 0xFF.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Decomposition:
- Shared package random_pkg holds:
  - state encoding constants S_IDLE=0, S_WAIT=1, S_CHECK=2, S_DONE=3;
  - default WIDTH and FRESH constants.
- One sub-module, rr_arbiter (NREQ): combinational next-grant index from req and rr_ptr, plus an any_req flag.
- The mask generator is a function inside random_server.

Test Plan:
- Reset, then rnd_in held at 0x1234, limit[0]=0xFFFF, req[0] raised once fresh_cnt is saturated -> valid[0] exactly 3 clks later, rnd_out=0x1234, busy low again the next cycle.
- Same rnd_in, limit[0]=0x0100 (mask 0x01FF) -> rnd_out=0x0034.
- rnd_in held at 0x01F0, limit[0]=0x0100 -> 8 rejections, then fallback rnd_out=0x00EF.
  - valid arrives 3+7*(FRESH+1) clks after the req sample.
  - With RANDOM_SERVER_STATS_EN: reject_cnt=8, fallback_cnt=1.
- req=4'b1111 held, limit=0 for all -> valid order 0,1,2,3,0; every rnd_out=0; consecutive LFSR captures at least FRESH clks apart.
- Drive rst low while in WAIT -> next edge shows valid=0, rnd_out=0, busy=0.
  - After release, req[2] alone is granted first; its result appears FRESH+3 clks after reset release.
- Connect to the real Random instance (noise=1), limit=0x00FF, 1000 requests -> every rnd_out<=0x00FF and no result repeats more than 10 times.

Source files
------------

// File: rtl/random_pkg.sv
// Shared definitions for the random value server: FSM state encoding and default sizing.
package random_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_FRESH     = 16;
  localparam int DEF_MAX_RETRY = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after rr_ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    any_req
);

  localparam int IW = $clog2(NREQ);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx[IW-1:0]]) begin
        grant = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/random_server.sv
// Shares one free-running LFSR among NREQ requesters, returning bounded values in [0, limit].
// Optional statistics counters are enabled with the RANDOM_SERVER_STATS_EN macro.
module random_server
  import random_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRESH     = DEF_FRESH,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      rnd_in,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] limit,
  output logic [NREQ-1:0]       valid,
  output logic [WIDTH-1:0]      rnd_out,
  output logic                  busy
`ifdef RANDOM_SERVER_STATS_EN
  ,
  output logic [15:0]           reject_cnt,
  output logic [7:0]            fallback_cnt
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int FW = $clog2(FRESH + 1);
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  // Smallest all-ones value covering v, by smearing the top set bit downward.
  function automatic logic [WIDTH-1:0] mask_of(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    m = v;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

  state_t           state, state_n;
  logic [FW-1:0]    fresh_cnt;
  logic [RW-1:0]    retry;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    grant_q;
  logic [WIDTH-1:0] lim_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] sample_q;

  logic [IW-1:0]    arb_grant;
  logic             any_req;
  logic [WIDTH-1:0] sel_limit;

  logic             do_grant;
  logic             do_cap;
  logic             do_result;
  logic             do_reject;
  logic             do_fallback;
  logic [WIDTH-1:0] result;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  assign sel_limit = limit[arb_grant*WIDTH +: WIDTH];
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    do_grant    = 1'b0;
    do_cap      = 1'b0;
    do_result   = 1'b0;
    do_reject   = 1'b0;
    do_fallback = 1'b0;
    result      = '0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          do_grant = 1'b1;
          state_n  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fresh_cnt == FW'(FRESH)) begin
          do_cap  = 1'b1;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sample_q <= lim_q) begin
          result    = sample_q;
          do_result = 1'b1;
          state_n   = S_DONE;
        end else begin
          do_reject = 1'b1;
          // Mask never exceeds 2*limit+1, so the folded value stays in range.
          if (retry == RW'(MAX_RETRY - 1)) begin
            do_fallback = 1'b1;
            result      = sample_q - lim_q - WIDTH'(1);
            do_result   = 1'b1;
            state_n     = S_DONE;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fresh_cnt <= '0;
      retry     <= '0;
      rr_ptr    <= IW'(NREQ - 1);
      grant_q   <= '0;
      lim_q     <= '0;
      mask_q    <= '0;
      sample_q  <= '0;
      valid     <= '0;
      rnd_out   <= '0;
    end else begin
      if (do_cap) begin
        fresh_cnt <= '0;
      end else if (fresh_cnt != FW'(FRESH)) begin
        fresh_cnt <= fresh_cnt + FW'(1);
      end

      if (do_grant) begin
        grant_q <= arb_grant;
        lim_q   <= sel_limit;
        mask_q  <= mask_of(sel_limit);
        retry   <= '0;
      end else if (do_reject && !do_fallback) begin
        retry <= retry + RW'(1);
      end

      if (do_cap) begin
        sample_q <= rnd_in & mask_q;
      end

      valid <= '0;
      if (do_result) begin
        valid   <= NREQ'(1) << grant_q;
        rnd_out <= result;
      end

      if (state == S_DONE) begin
        rr_ptr <= grant_q;
      end
    end
  end

`ifdef RANDOM_SERVER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reject_cnt   <= '0;
      fallback_cnt <= '0;
    end else begin
      if (do_reject && reject_cnt != 16'hFFFF) begin
        reject_cnt <= reject_cnt + 16'd1;
      end
      if (do_fallback && fallback_cnt != 8'hFF) begin
        fallback_cnt <= fallback_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
